// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - wash sequencer states, phase indices, program field map and phase-kind table
package wash_pkg;

    localparam int PROG_BITS  = 26;
    localparam int SUM_W      = 7;
    localparam int NUM_PHASES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        PH_W_FILL  = 3'd0,
        PH_W_AGIT  = 3'd1,
        PH_R_DRAIN = 3'd2,
        PH_R_SPIN  = 3'd3,
        PH_R_FILL  = 3'd4,
        PH_R_AGIT  = 3'd5,
        PH_D_DRAIN = 3'd6,
        PH_D_SPIN  = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        K_FILL  = 2'd0,
        K_AGIT  = 2'd1,
        K_DRAIN = 2'd2,
        K_SPIN  = 2'd3
    } kind_e;

    // Program word, MSB first: wash fill/agitate, rinse drain/spin/fill/agitate, dry drain/spin
    localparam int W_FILL_MSB  = 25, W_FILL_LSB  = 23;
    localparam int W_AGIT_MSB  = 22, W_AGIT_LSB  = 19;
    localparam int R_DRAIN_MSB = 18, R_DRAIN_LSB = 16;
    localparam int R_SPIN_MSB  = 15, R_SPIN_LSB  = 13;
    localparam int R_FILL_MSB  = 12, R_FILL_LSB  = 10;
    localparam int R_AGIT_MSB  = 9,  R_AGIT_LSB  = 6;
    localparam int D_DRAIN_MSB = 5,  D_DRAIN_LSB = 3;
    localparam int D_SPIN_MSB  = 2,  D_SPIN_LSB  = 0;

    function automatic logic [3:0] phase_dur(input logic [PROG_BITS-1:0] p, input logic [2:0] idx);
        logic [3:0] d;
        d = 4'd0;
        case (phase_e'(idx))
            PH_W_FILL:  d = {1'b0, p[W_FILL_MSB:W_FILL_LSB]};
            PH_W_AGIT:  d = p[W_AGIT_MSB:W_AGIT_LSB];
            PH_R_DRAIN: d = {1'b0, p[R_DRAIN_MSB:R_DRAIN_LSB]};
            PH_R_SPIN:  d = {1'b0, p[R_SPIN_MSB:R_SPIN_LSB]};
            PH_R_FILL:  d = {1'b0, p[R_FILL_MSB:R_FILL_LSB]};
            PH_R_AGIT:  d = p[R_AGIT_MSB:R_AGIT_LSB];
            PH_D_DRAIN: d = {1'b0, p[D_DRAIN_MSB:D_DRAIN_LSB]};
            PH_D_SPIN:  d = {1'b0, p[D_SPIN_MSB:D_SPIN_LSB]};
            default:    d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic kind_e phase_kind(input logic [2:0] idx);
        kind_e k;
        k = K_FILL;
        case (phase_e'(idx))
            PH_W_FILL, PH_R_FILL:   k = K_FILL;
            PH_W_AGIT, PH_R_AGIT:   k = K_AGIT;
            PH_R_DRAIN, PH_D_DRAIN: k = K_DRAIN;
            PH_R_SPIN, PH_D_SPIN:   k = K_SPIN;
            default:                k = K_FILL;
        endcase
        return k;
    endfunction

    function automatic logic [SUM_W-1:0] prog_sum(input logic [PROG_BITS-1:0] p);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            s = s + SUM_W'(phase_dur(p, 3'(i)));
        end
        return s;
    endfunction

endpackage

// File: rtl/wash_run_sequencer_phase_decode.sv
// rtl/wash_run_sequencer_phase_decode.sv - wash_phase_decode: state + phase to actuator enables
module wash_phase_decode
    import wash_pkg::*;
(
    input  state_e     i_state,
    input  logic [2:0] i_phase,
    output logic       o_valve_in,
    output logic       o_valve_out,
    output logic       o_motor,
    output logic       o_spin_hi
);

    always_comb begin
        o_valve_in  = 1'b0;
        o_valve_out = 1'b0;
        o_motor     = 1'b0;
        o_spin_hi   = 1'b0;
        // Actuators are live only while actually running; PAUSE/ERROR force everything off
        if (i_state == ST_RUN) begin
            case (phase_kind(i_phase))
                K_FILL:  o_valve_in = 1'b1;
                K_AGIT:  o_motor    = 1'b1;
                K_DRAIN: o_valve_out = 1'b1;
                K_SPIN: begin
                    o_valve_out = 1'b1;
                    o_motor     = 1'b1;
                    o_spin_hi   = 1'b1;
                end
                default: o_valve_in = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/wash_run_sequencer.sv
// rtl/wash_run_sequencer.sv - 8-phase timed wash program sequencer
// Optional done buzzer enabled by defining WASH_SEQ_BUZZER_EN.
module wash_run_sequencer
    import wash_pkg::*;
#(
    parameter int PROG_W   = 26,
    parameter int REMAIN_W = 7
`ifdef WASH_SEQ_BUZZER_EN
    ,
    parameter int BUZZ_TICKS = 3
`endif
) (
    input  logic                cp,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                start,
    input  logic                pause,
    input  logic                water_err,
    input  logic                clr,
    input  logic [PROG_W-1:0]   prog,
    output logic [2:0]          phase,
    output logic [3:0]          phase_remain,
    output logic [REMAIN_W-1:0] total_remain,
    output logic                valve_in,
    output logic                valve_out,
    output logic                motor,
    output logic                spin_hi,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                buzzer
);

    state_e              r_state, w_state_nxt;
    logic [PROG_W-1:0]   r_prog, w_prog_nxt;
    logic [2:0]          r_phase, w_phase_nxt;
    logic [2:0]          r_phase_o;
    logic [3:0]          r_prem, w_prem_nxt;
    logic [REMAIN_W-1:0] r_total, w_total_nxt;
    logic                r_vin, r_vout, r_motor, r_spin;

    logic                w_first_found, w_next_found;
    logic [2:0]          w_first_idx, w_next_idx;
    logic [3:0]          w_first_dur, w_next_dur;
    logic [REMAIN_W-1:0] w_first_total;
    logic                w_load, w_clear;
    logic                w_vin, w_vout, w_motor, w_spin;

    // Priority encoders: lowest nonzero phase of the incoming word, and of the latched word above r_phase
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = 3'd0;
        w_next_found  = 1'b0;
        w_next_idx    = 3'd0;
        for (int j = NUM_PHASES - 1; j >= 0; j--) begin
            if (phase_dur(prog, 3'(j)) != 4'd0) begin
                w_first_found = 1'b1;
                w_first_idx   = 3'(j);
            end
            if ((3'(j) > r_phase) && (phase_dur(r_prog, 3'(j)) != 4'd0)) begin
                w_next_found = 1'b1;
                w_next_idx   = 3'(j);
            end
        end
    end

    assign w_first_dur   = phase_dur(prog, w_first_idx);
    assign w_next_dur    = phase_dur(r_prog, w_next_idx);
    assign w_first_total = REMAIN_W'(prog_sum(prog));

    always_comb begin
        w_state_nxt = r_state;
        w_prog_nxt  = r_prog;
        w_phase_nxt = r_phase;
        w_prem_nxt  = r_prem;
        w_total_nxt = r_total;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (water_err)  w_state_nxt = ST_ERROR;
                else if (start) w_load = 1'b1;
            end
            ST_RUN: begin
                if (water_err) begin
                    w_state_nxt = ST_ERROR;
                end else if (pause) begin
                    w_state_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (r_prem > 4'd1) begin
                        w_prem_nxt  = r_prem - 4'd1;
                        w_total_nxt = r_total - REMAIN_W'(1);
                    end else if (w_next_found) begin
                        w_phase_nxt = w_next_idx;
                        w_prem_nxt  = w_next_dur;
                        w_total_nxt = r_total - REMAIN_W'(1);
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_phase_nxt = 3'd0;
                        w_prem_nxt  = 4'd0;
                        w_total_nxt = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (water_err)   w_state_nxt = ST_ERROR;
                else if (!pause) w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (clr)        w_clear = 1'b1;
                else if (start) w_load = 1'b1;
            end
            ST_ERROR: begin
                if (clr && !water_err) w_clear = 1'b1;
            end
            default: w_clear = 1'b1;
        endcase

        if (w_load) begin
            w_prog_nxt = prog;
            if (w_first_found) begin
                w_state_nxt = ST_RUN;
                w_phase_nxt = w_first_idx;
                w_prem_nxt  = w_first_dur;
                w_total_nxt = w_first_total;
            end else begin
                w_state_nxt = ST_DONE;
                w_phase_nxt = 3'd0;
                w_prem_nxt  = 4'd0;
                w_total_nxt = '0;
            end
        end
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
            w_prog_nxt  = '0;
            w_phase_nxt = 3'd0;
            w_prem_nxt  = 4'd0;
            w_total_nxt = '0;
        end
    end

    // Decode from next-state so registered actuators line up with the registered phase
    wash_phase_decode u_decode (
        .i_state     (w_state_nxt),
        .i_phase     (w_phase_nxt),
        .o_valve_in  (w_vin),
        .o_valve_out (w_vout),
        .o_motor     (w_motor),
        .o_spin_hi   (w_spin)
    );

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_prog    <= '0;
            r_phase   <= 3'd0;
            r_phase_o <= 3'd0;
            r_prem    <= 4'd0;
            r_total   <= '0;
            r_vin     <= 1'b0;
            r_vout    <= 1'b0;
            r_motor   <= 1'b0;
            r_spin    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prog    <= w_prog_nxt;
            r_phase   <= w_phase_nxt;
            r_phase_o <= ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE)) ? w_phase_nxt : 3'd0;
            r_prem    <= w_prem_nxt;
            r_total   <= w_total_nxt;
            r_vin     <= w_vin;
            r_vout    <= w_vout;
            r_motor   <= w_motor;
            r_spin    <= w_spin;
        end
    end

`ifdef WASH_SEQ_BUZZER_EN
    localparam int BUZZ_W = $clog2(BUZZ_TICKS + 1);

    logic [BUZZ_W-1:0] r_buzz_cnt;
    logic              w_enter_done;

    assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_buzz_cnt <= '0;
        end else if (w_enter_done) begin
            r_buzz_cnt <= BUZZ_W'(BUZZ_TICKS);
        end else if (clr || start) begin
            r_buzz_cnt <= '0;
        end else if (tick && (r_buzz_cnt != '0)) begin
            r_buzz_cnt <= r_buzz_cnt - BUZZ_W'(1);
        end
    end

    assign buzzer = (r_buzz_cnt != '0);
`else
    assign buzzer = 1'b0;
`endif

    assign phase        = r_phase_o;
    assign phase_remain = r_prem;
    assign total_remain = r_total;
    assign valve_in     = r_vin;
    assign valve_out    = r_vout;
    assign motor        = r_motor;
    assign spin_hi      = r_spin;
    assign busy         = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done         = (r_state == ST_DONE);
    assign err          = (r_state == ST_ERROR);

endmodule

// File: tb/tb_wash_run_sequencer.sv
// tb/tb_wash_run_sequencer.sv - self-checking bench for wash_run_sequencer against a schedule-level model
module tb_wash_run_sequencer;

    logic        cp, rst_n, tick, start, pause, water_err, clr;
    logic [25:0] prog;
    logic [2:0]  phase;
    logic [3:0]  phase_remain;
    logic [6:0]  total_remain;
    logic        valve_in, valve_out, motor, spin_hi, busy, done, err, buzzer;

    int checks   = 0;
    int failures = 0;

    wash_run_sequencer dut (
        .cp           (cp),
        .rst_n        (rst_n),
        .tick         (tick),
        .start        (start),
        .pause        (pause),
        .water_err    (water_err),
        .clr          (clr),
        .prog         (prog),
        .phase        (phase),
        .phase_remain (phase_remain),
        .total_remain (total_remain),
        .valve_in     (valve_in),
        .valve_out    (valve_out),
        .motor        (motor),
        .spin_hi      (spin_hi),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .buzzer       (buzzer)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    // Model: queue of (phase, seconds) for the nonzero phases, a cursor into it and the clocks left
    localparam int MD_IDLE = 0, MD_RUN = 1, MD_PAUSE = 2, MD_DONE = 3, MD_ERR = 4;
    int m_mode, m_pos, m_left, m_total, m_buzz;
    int m_ph[$];
    int m_du[$];

    function automatic int field_dur(input logic [25:0] p, input int i);
        int widths [8];
        int lsb;
        widths = '{3, 4, 3, 3, 3, 4, 3, 3};
        lsb = 26;
        for (int k = 0; k <= i; k++) lsb -= widths[k];
        return int'((p >> lsb) & ((26'd1 << widths[i]) - 26'd1));
    endfunction

    task automatic model_clear();
        m_ph.delete();
        m_du.delete();
        m_mode  = MD_IDLE;
        m_pos   = 0;
        m_left  = 0;
        m_total = 0;
    endtask

    task automatic model_begin(input logic [25:0] p);
        m_ph.delete();
        m_du.delete();
        m_total = 0;
        for (int i = 0; i < 8; i++) begin
            m_total += field_dur(p, i);
            if (field_dur(p, i) != 0) begin
                m_ph.push_back(i);
                m_du.push_back(field_dur(p, i));
            end
        end
        m_pos = 0;
        if (m_du.size() == 0) begin
            m_mode = MD_DONE;
            m_left = 0;
        end else begin
            m_mode = MD_RUN;
            m_left = m_du[0];
        end
    endtask

    task automatic model_step(input logic t, input logic s, input logic p, input logic w, input logic c,
                              input logic [25:0] pg);
        int prev;
        prev = m_mode;
        case (m_mode)
            MD_IDLE:  if (w) m_mode = MD_ERR; else if (s) model_begin(pg);
            MD_RUN: begin
                if (w) m_mode = MD_ERR;
                else if (p) m_mode = MD_PAUSE;
                else if (t) begin
                    m_total--;
                    m_left--;
                    if (m_left == 0) begin
                        m_pos++;
                        if (m_pos < m_du.size()) m_left = m_du[m_pos];
                        else begin
                            m_mode  = MD_DONE;
                            m_total = 0;
                        end
                    end
                end
            end
            MD_PAUSE: if (w) m_mode = MD_ERR; else if (!p) m_mode = MD_RUN;
            MD_DONE:  if (c) model_clear(); else if (s) model_begin(pg);
            MD_ERR:   if (c && !w) model_clear();
            default:  model_clear();
        endcase
        if (m_mode == MD_DONE && prev != MD_DONE) m_buzz = 3;
        else if (c || s) m_buzz = 0;
        else if (t && m_buzz > 0) m_buzz--;
    endtask

    function automatic logic [21:0] exp_vec();
        int   ph;
        logic vi, vo, mo, sp, bz;
        vi = 0; vo = 0; mo = 0; sp = 0;
        ph = (m_mode == MD_RUN || m_mode == MD_PAUSE) ? m_ph[m_pos] : 0;
        if (m_mode == MD_RUN) begin
            case (ph % 4)
                0: vi = 1;
                1: mo = 1;
                2: vo = 1;
                default: begin vo = 1; mo = 1; sp = 1; end
            endcase
        end
`ifdef WASH_SEQ_BUZZER_EN
        bz = (m_buzz > 0);
`else
        bz = 1'b0;
`endif
        return {3'(ph), 4'(m_left), 7'(m_total), vi, vo, mo, sp,
                (m_mode == MD_RUN || m_mode == MD_PAUSE), (m_mode == MD_DONE), (m_mode == MD_ERR), bz};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {phase, phase_remain, total_remain, valve_in, valve_out, motor, spin_hi, busy, done, err, buzzer};
    endfunction

    task automatic cycle(input logic t, input logic s, input logic p, input logic w, input logic c);
        tick = t; start = s; pause = p; water_err = w; clr = c;
        @(posedge cp);
        model_step(t, s, p, w, c, prog);
        #1;
        tick = 1'b0; start = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        tick = 0; start = 0; pause = 0; water_err = 0; clr = 0; prog = '0;
        rst_n = 1'b0;
        model_clear();
        m_buzz = 0;
        @(posedge cp);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 22'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 22'h0);
        end
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle_tick got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full_program();
        do_reset();
        prog = 26'h1D4AE25;
        cycle(0, 1, 0, 0, 0);
        prog = 26'($urandom);
        checks++;
        if (total_remain !== 7'd42 || phase !== 3'd0 || phase_remain !== 4'd3 || valve_in !== 1'b1) begin
            failures++;
            $display("FAIL full_start got=%0d/%0d/%0d/%b exp=42/0/3/1", total_remain, phase, phase_remain, valve_in);
        end
        for (int k = 1; k <= 42; k++) begin
            cycle(1, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL full_tick k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL full_idle k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (done !== 1'b1 || total_remain !== 7'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done got=%b/%0d/%b exp=1/0/0", done, total_remain, busy);
        end
    endtask

    task automatic test_dry_only();
        do_reset();
        prog = 26'h25;
        cycle(0, 1, 0, 0, 0);
        checks++;
        if (phase !== 3'd6 || phase_remain !== 4'd4 || total_remain !== 7'd9 || valve_out !== 1'b1 || motor !== 1'b0) begin
            failures++;
            $display("FAIL dry_start got=%0d/%0d/%0d/%b/%b exp=6/4/9/1/0", phase, phase_remain, total_remain, valve_out, motor);
        end
        for (int k = 1; k <= 9; k++) begin
            cycle(1, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL dry_tick k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            if (k == 4) begin
                checks++;
                if (phase !== 3'd7 || spin_hi !== 1'b1 || phase_remain !== 4'd5) begin
                    failures++;
                    $display("FAIL dry_spin got=%0d/%b/%0d exp=7/1/5", phase, spin_hi, phase_remain);
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL dry_done got=%b exp=1", done);
        end
    endtask

    task automatic test_pause();
        do_reset();
        prog = 26'h1D4AE25;
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 1, 0, 0);
            checks++;
            if (phase_remain !== 4'd5 || {valve_in, valve_out, motor, spin_hi} !== 4'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold got=%0d/%b/%b exp=5/0000/1", phase_remain,
                         {valve_in, valve_out, motor, spin_hi}, busy);
            end
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (phase_remain !== 4'd5 || motor !== 1'b1 || phase !== 3'd1 || total_remain !== 7'd34) begin
            failures++;
            $display("FAIL pause_resume got=%0d/%b/%0d/%0d exp=5/1/1/34", phase_remain, motor, phase, total_remain);
        end
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pause_after got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_water_err();
        do_reset();
        prog = 26'h1D4AE25;
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        checks++;
        if (err !== 1'b1 || valve_in !== 1'b0 || phase_remain !== 4'd2 || total_remain !== 7'd41) begin
            failures++;
            $display("FAIL werr_enter got=%b/%b/%0d/%0d exp=1/0/2/41", err, valve_in, phase_remain, total_remain);
        end
        cycle(1, 0, 0, 1, 1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL werr_clr_ignored got=%b exp=1", err);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL werr_low got=%h exp=%h", obs_vec(), exp_vec());
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || total_remain !== 7'd0 || phase_remain !== 4'd0) begin
            failures++;
            $display("FAIL werr_clear got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0", err, busy, done, total_remain, phase_remain);
        end
    endtask

    task automatic test_zero_prog();
        do_reset();
        prog = 26'h0;
        cycle(1, 1, 0, 0, 0);
        checks++;
        if (done !== 1'b1 || total_remain !== 7'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_prog got=%b/%0d/%b exp=1/0/0", done, total_remain, busy);
        end
        prog = 26'h1D4AE25;
        cycle(1, 1, 0, 0, 0);
        checks++;
        if (total_remain !== 7'd42 || busy !== 1'b1 || phase_remain !== 4'd3) begin
            failures++;
            $display("FAIL start_tick_coincident got=%0d/%b/%0d exp=42/1/3", total_remain, busy, phase_remain);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            prog = 26'($urandom);
            cycle(0, 1, 0, 0, 0);
            prog = 26'($urandom);
            for (int k = 0; k < 80 && m_mode != MD_DONE; k++) begin
                cycle(1, 0, 0, 0, 0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL b2b r=%0d k=%0d got=%h exp=%h", r, k, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        logic t, s, p, w, c;
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int k = 0; k < 300; k++) begin
                prog = 26'($urandom);
                t = ($urandom % 3) == 0;
                s = ($urandom % 12) == 0;
                p = ($urandom % 8) == 0;
                w = ($urandom % 40) == 0;
                c = ($urandom % 10) == 0;
                cycle(t, s, p, w, c);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random r=%0d k=%0d got=%h exp=%h", r, k, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        prog = 26'h1D4AE25;
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_clear();
        m_buzz = 0;
        #1;
        checks++;
        if (obs_vec() !== 22'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), 22'h0);
        end
        @(posedge cp);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef WASH_SEQ_BUZZER_EN
    task automatic test_buzzer();
        int high_ticks;
        do_reset();
        prog = 26'h25;
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 0, 0);
        high_ticks = 0;
        while (buzzer === 1'b1 && high_ticks < 10) begin
            cycle(1, 0, 0, 0, 0);
            high_ticks++;
        end
        checks++;
        if (high_ticks != 3) begin
            failures++;
            $display("FAIL buzz_len got=%0d exp=3", high_ticks);
        end
        prog = 26'h25;
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (buzzer !== 1'b0 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL buzz_clr got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_program();
        test_dry_only();
        test_pause();
        test_water_err();
        test_zero_prog();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef WASH_SEQ_BUZZER_EN
        test_buzzer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
